// File: rtl/timer_bus_pkg.sv
// Shared types and constants for the timer register bus.
//   op_e    : command opcodes carried on cmd_op
//   state_e : bus initiator FSM states
//   Register addresses and CTRL bit positions of the timer register block.
package timer_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RMW   = 2'd2,
    OP_POLL  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRmwWr,
    StPollRd,
    StPollGap,
    StResp
  } state_e;

  // Register map
  localparam int unsigned CTRL    = 0;
  localparam int unsigned STATUS  = 1;
  localparam int unsigned CNT     = 2;
  localparam int unsigned MATCH_1 = 3;
  localparam int unsigned MATCH_2 = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_START         = 7;
  localparam int unsigned CTRL_MODE_MSB      = 6;
  localparam int unsigned CTRL_MODE_LSB      = 5;
  localparam int unsigned CTRL_CLK_SEL       = 4;
  localparam int unsigned CTRL_MATCH0_INT_EN = 3;
  localparam int unsigned CTRL_MATCH1_INT_EN = 2;
  localparam int unsigned CTRL_OVF_INT_EN    = 1;

endpackage

// File: rtl/timer_bus_initiator.sv
// Bus initiator for the timer register interface.
// Takes one command at a time (WRITE / READ / RMW / POLL) over a valid/ready
// handshake, performs single-cycle bus accesses and returns one response.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op/addr/data/mask       command fields (latched on accept)
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_err           response payload (rsp_err = POLL timeout)
//   module_en, wr, addr, wdata  registered bus access outputs
//   rdata                       combinational bus read data
// Parameters: POLL_MAX in 1..255, POLL_GAP in 0..256.
module timer_bus_initiator
  import timer_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned POLL_MAX = 16,
  parameter int unsigned POLL_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              module_en,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  localparam logic [7:0] PollLast = 8'(POLL_MAX);
  localparam logic [7:0] GapLast  = 8'(POLL_GAP - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [7:0]        poll_cnt_q, poll_cnt_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [7:0]        poll_cnt_inc;
  logic              poll_match;

  logic              cmd_ready_d, rsp_valid_d, rsp_err_d, module_en_d, wr_d;
  logic [DATA_W-1:0] rsp_data_d, wdata_d;
  logic [ADDR_W-1:0] addr_d;

  assign poll_cnt_inc = poll_cnt_q + 8'd1;
  assign poll_match   = (rdata & mask_q) == (data_q & mask_q);

  // Outputs are registered, so every transition sets the bus/response values
  // that belong to the state being entered.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    mask_d      = mask_q;
    poll_cnt_d  = poll_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    module_en_d = module_en;
    wr_d        = wr;
    addr_d      = addr;
    wdata_d     = wdata;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d        = op_e'(cmd_op);
          data_d      = cmd_data;
          mask_d      = cmd_mask;
          addr_d      = cmd_addr;
          cmd_ready_d = 1'b0;
          module_en_d = 1'b1;
          unique case (op_e'(cmd_op))
            OP_WRITE: begin
              state_d = StWr;
              wr_d    = 1'b1;
              wdata_d = cmd_data;
            end
            OP_READ, OP_RMW: state_d = StRd;
            OP_POLL: begin
              state_d    = StPollRd;
              poll_cnt_d = 8'd0;
            end
          endcase
        end
      end

      StWr: begin
        state_d     = StResp;
        module_en_d = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_data_d  = data_q;
        rsp_err_d   = 1'b0;
      end

      StRd: begin
        // Old value is the response for both READ and RMW; capture it now.
        rsp_data_d = rdata;
        rsp_err_d  = 1'b0;
        if (op_q == OP_RMW) begin
          state_d = StRmwWr;
          wr_d    = 1'b1;
          wdata_d = (rdata & ~mask_q) | (data_q & mask_q);
        end else begin
          state_d     = StResp;
          module_en_d = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end

      StRmwWr: begin
        state_d     = StResp;
        module_en_d = 1'b0;
        wr_d        = 1'b0;
        rsp_valid_d = 1'b1;
      end

      StPollRd: begin
        poll_cnt_d = poll_cnt_inc;
        rsp_data_d = rdata;
        if (poll_match || poll_cnt_inc == PollLast) begin
          // A match on the final allowed read counts as success.
          state_d     = StResp;
          module_en_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !poll_match;
        end else if (POLL_GAP == 0) begin
          state_d = StPollRd;
        end else begin
          state_d     = StPollGap;
          module_en_d = 1'b0;
          gap_cnt_d   = 8'd0;
        end
      end

      StPollGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d     = StPollRd;
          module_en_d = 1'b1;
          gap_cnt_d   = 8'd0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OP_WRITE;
      data_q     <= '0;
      mask_q     <= '0;
      poll_cnt_q <= 8'd0;
      gap_cnt_q  <= 8'd0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      module_en  <= 1'b0;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_err    <= rsp_err_d;
      module_en  <= module_en_d;
      wr         <= wr_d;
      addr       <= addr_d;
      wdata      <= wdata_d;
    end
  end

endmodule
